// File: rtl/keypoint_collector_if.sv
// rtl/keypoint_collector_if.sv - record stream from keypoint_collector to the descriptor stage
interface keypoint_collector_if;
  logic        o_valid;
  logic        i_ready;
  logic [52:0] o_data;

  modport master (output o_valid, output o_data, input i_ready);
  modport slave  (input o_valid, input o_data, output i_ready);
endinterface

// File: rtl/keypoint_collector.sv
// rtl/keypoint_collector.sv - packs FAST keypoints into a FWFT FIFO with per-frame trailers; KP_SCORE_FILTER_EN enables score filtering
module keypoint_collector #(
  parameter int          DEPTH     = 64,
  parameter int          MAX_KP    = 500,
  parameter logic [7:0]  MIN_SCORE = 8'd0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_end,
  input  logic        i_flag,
  input  logic [9:0]  i_x,
  input  logic [9:0]  i_y,
  input  logic [7:0]  i_score,
  input  logic [11:0] i_cos,
  input  logic [11:0] i_sin,
  output logic        o_busy,
  output logic        o_err,
  keypoint_collector_if.master rec
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_LIM  = CW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [15:0]   KP_LIM   = 16'(MAX_KP);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_TRAILER} state_t;

  state_t        r_state, w_state_nxt;
  logic [15:0]   r_kp_cnt, w_kp_nxt;
  logic [15:0]   r_drop_cnt, w_drop_nxt;
  logic          r_err, w_err_nxt;
  logic [52:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_cnt;
  logic          w_valid, w_pop, w_push, w_keep, w_admit;
  logic [52:0]   w_push_data, w_kp_rec, w_tr_rec;

`ifdef KP_SCORE_FILTER_EN
  assign w_keep = (i_score >= MIN_SCORE);
`else
  logic w_unused_min_score;
  assign w_unused_min_score = ^MIN_SCORE;
  assign w_keep = 1'b1;
`endif

  assign w_valid  = (r_cnt != '0);
  assign w_pop    = w_valid && rec.i_ready;
  // Admission looks at the pre-pop count so a slot always remains for the trailer.
  assign w_admit  = i_flag && w_keep && (r_cnt < CNT_LIM) && (r_kp_cnt < KP_LIM);
  assign w_kp_rec = {1'b0, i_x, i_y, i_score, i_cos, i_sin};
  assign w_tr_rec = {1'b1, r_kp_cnt, r_drop_cnt, 20'd0};

  always_comb begin
    w_state_nxt = r_state;
    w_kp_nxt    = r_kp_cnt;
    w_drop_nxt  = r_drop_cnt;
    w_err_nxt   = r_err;
    w_push      = 1'b0;
    w_push_data = w_kp_rec;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_kp_nxt    = '0;
          w_drop_nxt  = '0;
          w_state_nxt = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (i_start) begin
          w_err_nxt  = 1'b1;
          w_kp_nxt   = '0;
          w_drop_nxt = '0;
        end else begin
          if (w_admit) begin
            w_push   = 1'b1;
            w_kp_nxt = r_kp_cnt + 16'd1;
          end else if (i_flag && w_keep && (r_drop_cnt != 16'hFFFF)) begin
            w_drop_nxt = r_drop_cnt + 16'd1;
          end
          if (i_end) w_state_nxt = S_TRAILER;
        end
      end
      S_TRAILER: begin
        // A back-to-back frame can leave the FIFO full; hold here until a slot opens.
        if ((r_cnt != CNT_FULL) || w_pop) begin
          w_push      = 1'b1;
          w_push_data = w_tr_rec;
          if (i_start) begin
            w_kp_nxt    = '0;
            w_drop_nxt  = '0;
            w_state_nxt = S_COLLECT;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_kp_cnt   <= '0;
      r_drop_cnt <= '0;
      r_err      <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_kp_cnt   <= w_kp_nxt;
      r_drop_cnt <= w_drop_nxt;
      r_err      <= w_err_nxt;
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= w_push_data;
  end

  assign rec.o_valid = w_valid;
  assign rec.o_data  = w_valid ? r_mem[r_rptr] : '0;
  assign o_busy      = (r_state != S_IDLE);
  assign o_err       = r_err;

endmodule

// File: tb/tb_keypoint_collector.sv
// tb/tb_keypoint_collector.sv - self-checking bench for keypoint_collector against a queue-based reference model
module tb_keypoint_collector;
  localparam int         DEPTH     = 64;
  localparam int         MAX_KP    = 100;
  localparam logic [7:0] MIN_SCORE = 8'd20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s, e, f, rdy;
  logic [9:0]  x, y;
  logic [7:0]  sc;
  logic [11:0] cs, sn;
  logic        busy, err;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  keypoint_collector_if kp_if();
  assign kp_if.i_ready = rdy;

  keypoint_collector #(.DEPTH(DEPTH), .MAX_KP(MAX_KP), .MIN_SCORE(MIN_SCORE)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(s), .i_end(e), .i_flag(f),
    .i_x(x), .i_y(y), .i_score(sc), .i_cos(cs), .i_sin(sn),
    .o_busy(busy), .o_err(err), .rec(kp_if.master)
  );

  // Reference model: the queue is the FIFO content, mode 0=idle 1=in frame 2=trailer owed
  logic [52:0] q[$];
  int          m_mode, m_kp, m_drop;
  bit          m_err;

  function automatic logic [52:0] kprec(input logic [9:0] xx, input logic [9:0] yy,
                                        input logic [7:0] ss, input logic [11:0] cc,
                                        input logic [11:0] nn);
    return {1'b0, xx, yy, ss, cc, nn};
  endfunction

  function automatic logic [52:0] trrec(input int k, input int d);
    logic [15:0] k16, d16;
    k16 = 16'(k);
    d16 = 16'(d);
    return {1'b1, k16, d16, 20'd0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_step();
    int          occ;
    bit          pop, push, keep;
    logic [52:0] nw;
    occ  = q.size();
    pop  = (occ > 0) && rdy;
    push = 1'b0;
    keep = 1'b1;
    nw   = '0;
`ifdef KP_SCORE_FILTER_EN
    keep = (sc >= MIN_SCORE);
`endif
    if (m_mode == 0) begin
      if (s) begin m_kp = 0; m_drop = 0; m_mode = 1; end
    end else if (m_mode == 1) begin
      if (s) begin
        m_err = 1'b1; m_kp = 0; m_drop = 0;
      end else begin
        if (f && keep) begin
          if (occ < DEPTH - 1 && m_kp < MAX_KP) begin
            push = 1'b1; nw = kprec(x, y, sc, cs, sn); m_kp++;
          end else if (m_drop < 65535) begin
            m_drop++;
          end
        end
        if (e) m_mode = 2;
      end
    end else begin
      if (occ < DEPTH || pop) begin
        push = 1'b1; nw = trrec(m_kp, m_drop);
        if (s) begin m_kp = 0; m_drop = 0; m_mode = 1; end
        else m_mode = 0;
      end
    end
    if (pop) void'(q.pop_front());
    if (push) q.push_back(nw);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("o_valid", 64'(kp_if.o_valid), 64'(q.size() > 0));
    check("o_data", 64'(kp_if.o_data), 64'(q.size() > 0 ? q[0] : 53'd0));
    check("o_busy", 64'(busy), 64'(m_mode != 0));
    check("o_err", 64'(err), 64'(m_err));
  endtask

  task automatic set_in(input logic ss, input logic ee, input logic ff, input logic [9:0] xx,
                        input logic [9:0] yy, input logic [7:0] scc, input logic [11:0] cc,
                        input logic [11:0] nn);
    s = ss; e = ee; f = ff; x = xx; y = yy; sc = scc; cs = cc; sn = nn;
  endtask

  task automatic idle_in();
    set_in(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q.delete();
    m_mode = 0; m_kp = 0; m_drop = 0; m_err = 1'b0;
    #2;
    check("rst_valid", 64'(kp_if.o_valid), 64'd0);
    check("rst_data", 64'(kp_if.o_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        vs, ve, vf;
    logic [9:0]  vx, vy;
    logic [7:0]  vsc;
    logic [11:0] vc, vn;
    logic        ev;
    logic [52:0] ed;
    logic        eb;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [52:0] last, head;
    int          thr, len, gap;

    idle_in();
    rdy = 1'b0;
    do_reset();

    // Basic frame: two keypoints and trailer with one-cycle latency
    tbl[0] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, '0, 1};
    tbl[1] = '{0, 0, 1, 10'd40, 10'd50, 8'd30, 12'h100, 12'h000, 1,
               {1'b0, 10'd40, 10'd50, 8'd30, 12'h100, 12'h000}, 1};
    tbl[2] = '{0, 0, 1, 10'd41, 10'd60, 8'd25, 12'h0F0, 12'h7FF, 1,
               {1'b0, 10'd41, 10'd60, 8'd25, 12'h0F0, 12'h7FF}, 1};
    tbl[3] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, '0, 1};
    tbl[4] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, {1'b1, 16'd2, 16'd0, 20'd0}, 0};
    tbl[5] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, '0, 0};
    rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_in(tbl[i].vs, tbl[i].ve, tbl[i].vf, tbl[i].vx, tbl[i].vy, tbl[i].vsc, tbl[i].vc, tbl[i].vn);
      cycle();
      check($sformatf("tbl%0d_valid", i), 64'(kp_if.o_valid), 64'(tbl[i].ev));
      check($sformatf("tbl%0d_data", i), 64'(kp_if.o_data), 64'(tbl[i].ed));
      check($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].eb));
    end

    // Overflow with stalled sink: 63 kept, 7 dropped, trailer takes the last slot
    rdy = 1'b0;
    set_in(1, 0, 0, 0, 0, 0, 0, 0); cycle();
    for (int i = 0; i < 70; i++) begin
      set_in(0, 0, 1, 10'(i), 10'(i + 1), 8'd50, 12'(i), ~12'(i));
      cycle();
    end
    set_in(0, 1, 0, 0, 0, 0, 0, 0); cycle();
    idle_in(); cycle();
    head = kprec(10'd0, 10'd1, 8'd50, 12'd0, 12'hFFF);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_head", 64'(kp_if.o_data), 64'(head));
    end
    rdy = 1'b1;
    n = 0; last = '0;
    for (int i = 0; i < 70; i++) begin
      if (kp_if.o_valid) begin n++; last = kp_if.o_data; end
      cycle();
    end
    check("drain_count", 64'(n), 64'd64);
    check("drain_trailer", 64'(last), 64'(trrec(63, 7)));

    // Per-frame keypoint cap
    set_in(1, 0, 0, 0, 0, 0, 0, 0); cycle();
    for (int i = 0; i < MAX_KP + 5; i++) begin
      set_in(0, 0, 1, 10'(i), 10'd3, 8'd40, 12'd5, 12'd6);
      cycle();
    end
    set_in(0, 1, 0, 0, 0, 0, 0, 0); cycle();
    idle_in(); cycle();
    check("cap_trailer", 64'(kp_if.o_data), 64'(trrec(MAX_KP, 5)));
    cycle();

    // Flag in the same cycle as end
    set_in(1, 0, 0, 0, 0, 0, 0, 0); cycle();
    set_in(0, 1, 1, 10'd7, 10'd8, 8'd99, 12'd1, 12'd2); cycle();
    check("end_flag_kp", 64'(kp_if.o_data), 64'(kprec(10'd7, 10'd8, 8'd99, 12'd1, 12'd2)));
    idle_in(); cycle();
    check("end_flag_trailer", 64'(kp_if.o_data), 64'(trrec(1, 0)));
    cycle();

    // Start without end: sticky error, counters restart
    set_in(1, 0, 0, 0, 0, 0, 0, 0); cycle();
    set_in(0, 0, 1, 10'd1, 10'd1, 8'd30, 12'd0, 12'd0); cycle();
    set_in(1, 0, 0, 0, 0, 0, 0, 0); cycle();
    check("err_set", 64'(err), 64'd1);
    set_in(0, 0, 1, 10'd2, 10'd2, 8'd30, 12'd0, 12'd0); cycle();
    set_in(0, 1, 0, 0, 0, 0, 0, 0); cycle();
    idle_in(); cycle();
    check("restart_trailer", 64'(kp_if.o_data), 64'(trrec(1, 0)));
    cycle(); cycle();
    check("err_sticky", 64'(err), 64'd1);

    // Reset in the middle of a frame with records buffered
    rdy = 1'b0;
    set_in(1, 0, 0, 0, 0, 0, 0, 0); cycle();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 1, 10'(i), 10'd9, 8'd60, 12'd3, 12'd4); cycle();
    end
    idle_in();
    do_reset();
    cycle();

`ifdef KP_SCORE_FILTER_EN
    rdy = 1'b1;
    set_in(1, 0, 0, 0, 0, 0, 0, 0); cycle();
    set_in(0, 0, 1, 10'd2, 10'd2, 8'd10, 12'd0, 12'd0); cycle();
    set_in(0, 0, 1, 10'd3, 10'd3, 8'd30, 12'd0, 12'd0); cycle();
    check("filt_kp", 64'(kp_if.o_data), 64'(kprec(10'd3, 10'd3, 8'd30, 12'd0, 12'd0)));
    set_in(0, 1, 0, 0, 0, 0, 0, 0); cycle();
    idle_in(); cycle();
    check("filt_trailer", 64'(kp_if.o_data), 64'(trrec(1, 0)));
    cycle();
`endif

    // Randomized frames against the model
    for (int fr = 0; fr < 25; fr++) begin
      thr = $urandom_range(1, 4);
      set_in(1, 0, 0, 0, 0, 0, 0, 0);
      rdy = ($urandom % 4) < thr;
      cycle();
      len = $urandom_range(0, 80);
      for (int j = 0; j < len; j++) begin
        set_in(0, 0, 1'($urandom % 2), 10'($urandom), 10'($urandom), 8'($urandom),
               12'($urandom), 12'($urandom));
        rdy = ($urandom % 4) < thr;
        cycle();
      end
      set_in(0, 1, 1'($urandom % 2), 10'($urandom), 10'($urandom), 8'($urandom),
             12'($urandom), 12'($urandom));
      rdy = ($urandom % 4) < thr;
      cycle();
      idle_in();
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        rdy = ($urandom % 4) < thr;
        cycle();
      end
    end
    idle_in();
    rdy = 1'b1;
    for (int i = 0; i < DEPTH + 4; i++) cycle();
    check("final_empty", 64'(kp_if.o_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
